// File: rtl/count_event_pkg.sv
// Shared types for the count event recorder.
// Optional timestamp build: define COUNT_EVENT_TIMESTAMP_EN to prefix every
// record with a free-running cycle count.
package count_event_pkg;

    // Default timestamp width; the top-level TS_W parameter defaults to this.
    localparam int TS_W_DEF = 16;

    // Record kind codes as they appear in ev_data[7:6].
    typedef enum logic [1:0] {
        KIND_WIN      = 2'b00,
        KIND_LOSE     = 2'b01,
        KIND_GAMEOVER = 2'b10,
        KIND_TIE      = 2'b11
    } kind_e;

    // Recorder lifecycle.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_CLOSING = 2'b01,
        ST_DRAIN   = 2'b10,
        ST_DONE    = 2'b11
    } rec_state_e;

    // The 8-bit payload common to both builds.
    typedef struct packed {
        kind_e       kind;
        logic [1:0]  who;
        logic [3:0]  counter;
    } event_body_t;

    // Full record as seen by a consumer at the default timestamp width.
    typedef struct packed {
`ifdef COUNT_EVENT_TIMESTAMP_EN
        logic [TS_W_DEF-1:0] ts;
`endif
        event_body_t body;
    } event_rec_t;

    // A simultaneous win and lose edge collapses into one TIE record.
    function automatic kind_e classify(input logic win_rise, input logic lose_rise);
        kind_e k;
        if (win_rise && lose_rise) begin
            k = KIND_TIE;
        end else if (win_rise) begin
            k = KIND_WIN;
        end else begin
            k = KIND_LOSE;
        end
        return k;
    endfunction

endpackage

// File: rtl/count_event_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on pop_data whenever
// the FIFO is not empty, and pop_data reads as zero when it is empty.
// A push while full is only taken if a pop happens in the same cycle.
module count_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are qualified by level so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/count_event_recorder.sv
// Count event recorder: turns winner/loser rising edges and the gameover
// assertion from the upstream counter into records queued for a consumer.
// Optional build macro: COUNT_EVENT_TIMESTAMP_EN adds a free-running TS_W-bit
// cycle counter and prefixes each record with its value at capture time.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | recording WIN/LOSE/TIE edges; gameover moves to ST_CLOSING
// ST_CLOSING | waiting for FIFO space to push the single GAMEOVER record
// ST_DRAIN   | no new records; waiting for the consumer to empty the FIFO
// ST_DONE    | closed and drained; done held high until reset
module count_event_recorder
    import count_event_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8,
`ifdef COUNT_EVENT_TIMESTAMP_EN
    parameter int TS_W   = TS_W_DEF,
    localparam int REC_W = TS_W + 8,
`else
    localparam int REC_W = 8,
`endif
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        counter,
    input  logic              winner,
    input  logic              loser,
    input  logic              gameover,
    input  logic [1:0]        who,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [REC_W-1:0]  ev_data,
    output logic [LVL_W-1:0]  ev_level,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              done
);

    logic        winner_q;
    logic        loser_q;
    logic        win_rise;
    logic        lose_rise;
    rec_state_e  state;
    event_body_t body;
    logic [REC_W-1:0] rec;
    logic        push_req;
    logic        has_space;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        drop;

    assign win_rise  = winner & ~winner_q;
    assign lose_rise = loser & ~loser_q;

    // Previous-cycle copies of the flags; cleared so a flag already high at
    // reset release is seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner_q <= 1'b0;
            loser_q  <= 1'b0;
        end else begin
            winner_q <= winner;
            loser_q  <= loser;
        end
    end

`ifdef COUNT_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle count used to stamp records; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign rec = {ts_q, body};
`else
    assign rec = body;
`endif

    // Decide whether a record is offered this cycle and what it contains.
    always_comb begin
        push_req     = 1'b0;
        body.kind    = classify(win_rise, lose_rise);
        body.who     = who;
        body.counter = counter;
        case (state)
            ST_RUN: begin
                push_req = win_rise | lose_rise;
            end
            ST_CLOSING: begin
                push_req  = 1'b1;
                body.kind = KIND_GAMEOVER;
            end
            default: begin
                push_req = 1'b0;
            end
        endcase
    end

    // A full FIFO still has room when its head leaves in the same cycle.
    assign fifo_pop  = ~fifo_empty & ev_ready;
    assign has_space = ~fifo_full | fifo_pop;
    assign fifo_push = push_req & has_space;
    // Only RUN-phase events can be lost; CLOSING simply waits for space.
    assign drop      = push_req & ~has_space & (state == ST_RUN);
    assign ev_valid  = ~fifo_empty;

    // Lifecycle FSM with registered done flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (gameover) begin
                        state <= ST_CLOSING;
                    end
                end
                ST_CLOSING: begin
                    if (has_space) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (ev_level == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            endcase
        end
    end

    // Sticky overflow flag and saturating count of lost events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != {DROP_W{1'b1}}) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end
    end

    count_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (rec),
        .pop       (fifo_pop),
        .pop_data  (ev_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (ev_level)
    );

endmodule
